// File: rtl/axi_burst_pkg.sv
// Shared types for the AXI burst master: burst and response
// encodings, the master FSM states and the legal WRAP lengths.
package axi_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WADDR,
    S_WDATA,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_e;

  function automatic logic wrap_len_ok(
    input logic [8:0] len
  );
    return (len == 9'd2) || (len == 9'd4) ||
           (len == 9'd8) || (len == 9'd16);
  endfunction

endpackage

// File: rtl/axi_beat_addr_gen.sv
// Per-beat byte address tracker for FIXED/INCR/WRAP bursts.
// Ports: load_i seeds from the command, adv_i steps one beat, addr_o.
module axi_beat_addr_gen
  import axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [8:0]        len_i,
  input  logic [2:0]        size_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] bytes, span;
  logic [ADDR_W-1:0] lower, upper;
  logic [ADDR_W-1:0] align, step;

  always_comb begin
    bytes = ADDR_W'(1) << size_i;
    span  = ADDR_W'(len_i) << size_i;
    // span is a power of two for legal WRAP bursts
    lower = addr_i & ~(span - ADDR_W'(1));
    upper = lower + span;
    align = addr_i & ~(bytes - ADDR_W'(1));
    step  = cur_q + bytes;
  end

  always_comb begin
    cur_d = cur_q;
    if (load_i) begin
      cur_d = (burst_i == BURST_FIXED) ? addr_i : align;
    end else if (adv_i) begin
      unique case (burst_i)
        BURST_FIXED: cur_d = cur_q;
        BURST_WRAP:  cur_d = (step == upper) ? lower : step;
        default:     cur_d = step;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) cur_q <= '0;
    else         cur_q <= cur_d;
  end

  assign addr_o = cur_q;

endmodule

// File: rtl/axi_burst_master.sv
// Single-command AXI burst master: checks the command, issues AW/W/B
// or AR/R, streams data to/from the local side, pulses done with status.
// Ports: cmd_* request, wd_*/rd_* local streams, done/err/proto_err,
// AXI aw/w/b/ar/r channels. Macro AXI_BURST_MASTER_BEAT_ADDR_EN adds
// the beat_addr output.
module axi_burst_master
  import axi_burst_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [8:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        err,
  output logic              proto_err,
`ifdef AXI_BURST_MASTER_BEAT_ADDR_EN
  output logic [ADDR_W-1:0] beat_addr,
`endif
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic [1:0]        rresp
);

  localparam logic [2:0] MAX_SIZE =
    3'($clog2(DATA_W / 8));
  localparam logic [8:0] MAX_LEN9 = 9'(MAX_LEN);

  state_e            state_q, state_d;
  logic              live_q;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              perr_q, perr_d;

  logic [8:0]        len_m1;
  logic [ADDR_W-1:0] size_mask;
  logic              illegal;
  logic              is_last;

  always_comb begin
    len_m1    = len_q - 9'd1;
    size_mask = ~({ADDR_W{1'b1}} << size_q);
    is_last   = (cnt_q == len_m1);
    illegal   = (len_q == 9'd0) ||
                (len_q > MAX_LEN9) ||
                (size_q > MAX_SIZE) ||
                (burst_q == 2'd3) ||
                ((burst_q == BURST_WRAP) &&
                 (!wrap_len_ok(len_q) ||
                  (|(addr_q & size_mask))));
  end

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    perr_d    = perr_q;
    cmd_ready = 1'b0;
    wd_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = 1'b0;
    err       = 2'b00;
    proto_err = 1'b0;
    awvalid   = 1'b0;
    awaddr    = '0;
    awlen     = '0;
    awsize    = '0;
    awburst   = '0;
    wvalid    = 1'b0;
    wdata     = '0;
    wlast     = 1'b0;
    bready    = 1'b0;
    arvalid   = 1'b0;
    araddr    = '0;
    arlen     = '0;
    arsize    = '0;
    arburst   = '0;
    rready    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // held low until the first edge after reset release
        cmd_ready = live_q;
        if (cmd_valid && live_q) begin
          write_d = cmd_write;
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        cnt_d = '0;
        if (illegal) begin
          err_d   = RESP_SLVERR;
          state_d = S_DONE;
        end else begin
          state_d = write_q ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: begin
        awvalid = 1'b1;
        awaddr  = addr_q;
        awlen   = len_m1[7:0];
        awsize  = size_q;
        awburst = burst_q;
        if (awready) state_d = S_WDATA;
      end
      S_WDATA: begin
        wvalid   = wd_valid;
        wdata    = wd_data;
        wd_ready = wready;
        wlast    = is_last;
        if (wd_valid && wready) begin
          if (is_last) state_d = S_WRESP;
          else         cnt_d   = cnt_q + 9'd1;
        end
      end
      S_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = bresp;
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        arlen   = len_m1[7:0];
        arsize  = size_q;
        arburst = burst_q;
        if (arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        rd_valid = rvalid;
        rd_data  = rdata;
        rd_last  = is_last;
        rready   = rd_ready;
        if (rvalid && rd_ready) begin
          if ((err_q == RESP_OKAY) &&
              (rresp != RESP_OKAY)) begin
            err_d = rresp;
          end
          if (rlast != is_last) perr_d = 1'b1;
          if (is_last) state_d = S_DONE;
          else         cnt_d   = cnt_q + 9'd1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_q;
        proto_err = perr_q;
        write_d   = 1'b0;
        addr_d    = '0;
        len_d     = '0;
        size_d    = '0;
        burst_d   = '0;
        cnt_d     = '0;
        err_d     = RESP_OKAY;
        perr_d    = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      perr_q  <= perr_d;
    end
  end

`ifdef AXI_BURST_MASTER_BEAT_ADDR_EN
  logic [ADDR_W-1:0] ba;
  logic              ba_adv;

  assign ba_adv =
    ((state_q == S_WDATA) && wd_valid && wready) ||
    ((state_q == S_RDATA) && rvalid && rd_ready);

  axi_beat_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_beat_addr (
    .aclk    (aclk),
    .resetn  (resetn),
    .load_i  (state_q == S_CHECK),
    .adv_i   (ba_adv),
    .addr_i  (addr_q),
    .len_i   (len_q),
    .size_i  (size_q),
    .burst_i (burst_q),
    .addr_o  (ba)
  );

  assign beat_addr =
    ((state_q == S_WDATA) || (state_q == S_RDATA))
      ? ba : '0;
`endif

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- Burst-issuing master that sits directly upstream of the team's AXI slave/memory block. It drives the AW/W/B and AR/R channels.
- Accepts one command at a time from a local controller (testbench sequencer or DMA front end). The command carries address, beat count, beat size and burst type.
- Streams write data in from the local side and streams read data out to the local side.
- Reports completion and response status once per command.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data bus width in bits; 8 or more, power of two.
- MAX_LEN, 16, largest legal beat count per command; 1 to 256.

Ports:
- aclk  in  1  clock; all logic rising-edge.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address in bytes.
- cmd_len  in  9  beat count, 1..MAX_LEN.
- cmd_size  in  3  log2 of bytes per beat.
- cmd_burst  in  2  0 = FIXED, 1 = INCR, 2 = WRAP.
- wd_valid / wd_ready / wd_data  in / out / in  1 / 1 / DATA_W  local write-data stream.
- rd_valid / rd_ready / rd_data / rd_last  out / in / out / out  1 / 1 / DATA_W / 1  local read-data stream.
- done  out  1  one-cycle completion pulse.
- err  out  2  response status; valid while done is high.
- proto_err  out  1  rlast mismatch flag; valid while done is high.
- awvalid / awready / awaddr / awlen / awsize / awburst  out / in / out / out / out / out  1 / 1 / ADDR_W / 8 / 3 / 2
- wvalid / wready / wdata / wlast  out / in / out / out  1 / 1 / DATA_W / 1
- bvalid / bready / bresp  in / out / in  1 / 1 / 2
- arvalid / arready / araddr / arlen / arsize / arburst  out / in / out / out / out / out  1 / 1 / ADDR_W / 8 / 3 / 2
- rvalid / rready / rdata / rlast / rresp  in / out / in / in / in  1 / 1 / DATA_W / 1 / 2

Behaviour:
- Reset: one clock, aclk; asynchronous active-low reset, resetn.
  - On resetn low: all outputs go to 0 immediately and the state goes to IDLE; cmd_ready then rises on the first edge after release.
  - A reset mid-burst abandons the burst; no done pulse is produced for it.
- State machine: IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready: latch the full command and go to CHECK.
- CHECK (one cycle): the command is illegal if any of the following holds:
  - cmd_len == 0 or cmd_len > MAX_LEN;
  - 2^cmd_size > DATA_W/8;
  - cmd_burst == 3;
  - WRAP with cmd_len not in {2, 4, 8, 16};
  - WRAP with cmd_addr not aligned to 2^cmd_size.
- Illegal command: go to DONE with err = 2'b10 and no bus activity.
- Legal command: go to WADDR or RADDR according to cmd_write.
- WADDR / RADDR:
  - Assert awvalid or arvalid with addr = cmd_addr, len = cmd_len-1, size = cmd_size, burst = cmd_burst.
  - Hold valid and payload stable until the ready handshake; valid never drops before the handshake.
  - After the handshake go to WDATA or RDATA.
- WDATA (combinational pass-through):
  - wvalid = wd_valid, wdata = wd_data, wd_ready = wready.
  - The beat counter increments only on wvalid && wready.
  - wlast = 1 only when the counter equals cmd_len-1.
  - After the last beat handshake go to WRESP.
- WRESP:
  - bready = 1.
  - On bvalid: latch bresp and go to DONE.
- RDATA (combinational pass-through):
  - rd_valid = rvalid, rd_data = rdata, rready = rd_ready.
  - rd_last = 1 on counted beat cmd_len-1.
  - Beats count on rvalid && rready.
  - The first non-zero rresp is latched (sticky).
  - proto_err is set if rlast is asserted on any beat other than the last, or is not asserted on the last beat.
  - After beat cmd_len go to DONE.
- DONE (one cycle):
  - done = 1, err = latched response, proto_err = latched flag.
  - Then return to IDLE and clear all latches.
- Latency:
  - done rises the cycle after the final B handshake or final R beat.
  - A minimum legal burst occupies IDLE + CHECK + address + data + (WRESP) + DONE.
- Beat counter width is 9 bits; no arithmetic overflow is permitted.

Optional Feature:
- Macro: AXI_BURST_MASTER_BEAT_ADDR_EN.
- When defined:
  - Adds output beat_addr [ADDR_W-1:0], valid during WDATA/RDATA and advancing on each beat handshake.
  - FIXED: beat_addr = cmd_addr on every beat.
  - INCR: beat_addr = aligned_addr + n*bytes, where aligned_addr = cmd_addr with the low cmd_size bits cleared.
  - WRAP: lower = (cmd_addr / (len*bytes)) * (len*bytes) and upper = lower + len*bytes; when next reaches upper it wraps to lower.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package axi_burst_pkg:
  - burst-type constants FIXED / INCR / WRAP;
  - response constants OKAY / EXOKAY / SLVERR / DECERR;
  - the state enum;
  - legal WRAP length set.
- Sub-module axi_beat_addr_gen (beat address calculator), instantiated only under the macro.

Test Plan:
- INCR write, addr 0x10, len 4, size 2, wd data 1..4, awready delayed 2 cycles -> awaddr 0x10 / awlen 3 / awsize 2 stable until handshake; 4 W beats with wlast only on beat 4; bresp 0 -> single done pulse, err 0.
- WRAP read, addr 0x38, len 4, size 2 -> araddr 0x38, arburst 2, rd_last on beat 4; with macro on, beat_addr = 0x38, 0x3C, 0x30, 0x34.
- WRAP write with len 3 -> awvalid never rises; done 2 cycles after command acceptance with err 2'b10.
- wd_valid toggled and wready held low 3 cycles mid-burst -> counter and wlast advance only on handshakes; wdata stable while wvalid && !wready.
- Read len 4 with rresp 2'b10 on beat 2 and rlast on beat 3 -> err 2'b10, proto_err 1 at done.
- resetn low during WDATA beat 2 -> all outputs 0 asynchronously, no done pulse; cmd_ready 1 on the first edge after release; a new INCR write then completes normally.
